// File: rtl/serial_word_endpoint.sv
// Host-side bit-serial endpoint: LSB-first TX serializer and RX deserializer, both with valid/ready handshakes.
// Optional feature macro SERIAL_LOOPBACK_EN adds i_loopback, routing TX serial output straight into RX.
module serial_word_endpoint #(
  parameter int DATA_WIDTH  = 24,
  parameter int IDLE_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef SERIAL_LOOPBACK_EN
  input  logic                  i_loopback,
`endif
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_ser_dout,
  output logic                  o_ser_dout_valid,
  input  logic                  i_ser_ready,
  input  logic                  i_ser_din,
  input  logic                  i_ser_din_valid,
  output logic                  o_ser_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_WAIT, RX_SHIFT, RX_HOLD} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_shift;
  logic [CW-1:0]         tx_cnt, rx_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  tx_ser_ready, rx_din, rx_din_valid;
  logic                  din_valid_q, rx_edge, rx_pend;

`ifdef SERIAL_LOOPBACK_EN
  assign tx_ser_ready = i_loopback ? o_ser_ready      : i_ser_ready;
  assign rx_din       = i_loopback ? o_ser_dout       : i_ser_din;
  assign rx_din_valid = i_loopback ? o_ser_dout_valid : i_ser_din_valid;
`else
  assign tx_ser_ready = i_ser_ready;
  assign rx_din       = i_ser_din;
  assign rx_din_valid = i_ser_din_valid;
`endif

  assign o_tx_ready       = (tx_state == TX_IDLE);
  assign o_ser_dout_valid = (tx_state == TX_SHIFT);
  assign o_ser_dout       = o_ser_dout_valid & tx_sr[0];

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (i_tx_valid) tx_next = TX_SHIFT;
      TX_SHIFT: if (tx_ser_ready && tx_cnt == BIT_LAST) tx_next = TX_GAP;
      TX_GAP:   if (gap_cnt == GAP_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state <= TX_IDLE;
      tx_sr    <= '0;
      tx_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_state <= tx_next;
      case (tx_state)
        TX_IDLE: begin
          if (i_tx_valid) tx_sr <= i_tx_data;
          tx_cnt <= '0;
        end
        TX_SHIFT: begin
          // Zero fill keeps o_ser_dout low once the word has drained.
          if (tx_ser_ready) begin
            tx_sr  <= tx_sr >> 1;
            tx_cnt <= tx_cnt + CW'(1);
          end
          gap_cnt <= '0;
        end
        TX_GAP:  gap_cnt <= gap_cnt + GW'(1);
        default: gap_cnt <= '0;
      endcase
    end
  end

  // A word starts on a rising edge of the peer's valid, not on its level.
  assign rx_edge     = rx_din_valid & ~din_valid_q;
  assign rx_shift    = {rx_din, rx_sr[DATA_WIDTH-1:1]};
  assign o_ser_ready = (rx_state == RX_SHIFT);
  assign o_rx_valid  = (rx_state == RX_HOLD);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_WAIT:  if (rx_edge) rx_next = RX_SHIFT;
      RX_SHIFT: if (rx_cnt == BIT_LAST) rx_next = RX_HOLD;
      RX_HOLD:  if (i_rx_ready) rx_next = (rx_pend || rx_edge) ? RX_SHIFT : RX_WAIT;
      default:  rx_next = RX_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state    <= RX_WAIT;
      rx_sr       <= '0;
      rx_cnt      <= '0;
      rx_pend     <= 1'b0;
      din_valid_q <= 1'b0;
      o_rx_data   <= '0;
    end else begin
      rx_state    <= rx_next;
      din_valid_q <= rx_din_valid;
      if (rx_state == RX_SHIFT) begin
        rx_sr  <= rx_shift;
        rx_cnt <= rx_cnt + CW'(1);
        if (rx_cnt == BIT_LAST) o_rx_data <= rx_shift;
      end else begin
        rx_cnt <= '0;
      end
      // An edge arriving at the HOLD exit is consumed directly by rx_next.
      if (rx_state == RX_HOLD && i_rx_ready) rx_pend <= 1'b0;
      else if (rx_edge && rx_state != RX_WAIT) rx_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_word_endpoint.sv
// Directed bench for serial_word_endpoint: reset, TX sequence and backpressure, RX hold/pending, looped-back words.
module tb_serial_word_endpoint;

  logic        tb_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, ser_dout, ser_dout_valid, ser_ready;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        drv_ready = 1'b0, drv_din = 1'b0, drv_din_valid = 1'b0;
  logic        ext_lb = 1'b0, lb_int = 1'b0;
  logic        peer_ready, peer_din, peer_din_valid;

  int errs = 0;
  int checks = 0;

  // Bench-side loopback wiring, so the round trip is exercised without the optional port.
  assign peer_ready     = ext_lb ? ser_ready      : drv_ready;
  assign peer_din       = ext_lb ? ser_dout       : drv_din;
  assign peer_din_valid = ext_lb ? ser_dout_valid : drv_din_valid;

  always #5 tb_clk = ~tb_clk;

  serial_word_endpoint #(.DATA_WIDTH(24), .IDLE_CYCLES(1)) dut (
    .i_clk           (tb_clk),
    .i_rst_n         (rst_n),
`ifdef SERIAL_LOOPBACK_EN
    .i_loopback      (lb_int),
`endif
    .i_tx_data       (tx_data),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (tx_ready),
    .o_ser_dout      (ser_dout),
    .o_ser_dout_valid(ser_dout_valid),
    .i_ser_ready     (peer_ready),
    .i_ser_din       (peer_din),
    .i_ser_din_valid (peer_din_valid),
    .o_ser_ready     (ser_ready),
    .o_rx_data       (rx_data),
    .o_rx_valid      (rx_valid),
    .i_rx_ready      (rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic lb_word(input logic [23:0] w, input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 100) begin tick(); n++; end
    tx_data = w; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!rx_valid && n < 100) begin tick(); n++; end
    check(tag, {7'd0, rx_valid, rx_data}, {8'h01, w});
  endtask

  task automatic abort_word(input string tag);
    int seen_rx, seen_tx;
    tx_data = 24'hFFFFFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_out"}, {ser_dout_valid, ser_ready, rx_valid, tx_ready}, 4'b0001);
    tick();
    rst_n = 1'b1;
    seen_rx = 0; seen_tx = 0;
    for (int i = 0; i < 40; i++) begin
      if (rx_valid) seen_rx++;
      if (ser_dout_valid) seen_tx++;
      tick();
    end
    check({tag, "_no_rx"}, seen_rx, 0);
    check({tag, "_no_tx"}, seen_tx, 0);
    lb_word(24'h3C5A69, {tag, "_recover"});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_seq[24] = '{0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    logic [23:0] w, w2, cap;
    int nb, stall, vcyc;

    // Reset with live requests on both sides.
    tx_valid = 1'b1; drv_din_valid = 1'b1; tx_data = 24'h123456;
    repeat (3) tick();
    check("rst_tx_ready", tx_ready, 1);
    check("rst_outs", {ser_dout, ser_dout_valid, ser_ready, rx_valid}, 4'b0000);
    check("rst_rx_data", rx_data, 0);
    tx_valid = 1'b0; drv_din_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {ser_dout_valid, ser_ready, tx_ready}, 3'b001);

    // TX with the peer always ready.
    drv_ready = 1'b1;
    tx_data = 24'hA5C3F0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("tx_busy", tx_ready, 0);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("tx_bit%0d", i), {ser_dout_valid, ser_dout}, {1'b1, tx_seq[i][0]});
      tick();
    end
    check("tx_gap", {ser_dout_valid, tx_ready}, 2'b00);
    tick();
    check("tx_ready_back", {ser_dout_valid, tx_ready}, 2'b01);

    // TX backpressure at bit 7.
    w = 24'h5A3C96; cap = '0; nb = 0; stall = 0; vcyc = 0;
    tx_data = w; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (ser_dout_valid) begin
        vcyc++;
        if (nb == 7 && stall < 5) begin
          drv_ready = 1'b0;
          stall++;
          check("bp_hold", ser_dout, w[7]);
        end else begin
          drv_ready = 1'b1;
          if (nb < 24) cap[nb] = ser_dout;
          nb++;
        end
      end else if (vcyc > 0) begin
        break;
      end
      tick();
    end
    drv_ready = 1'b1;
    check("bp_valid_cycles", vcyc, 29);
    check("bp_bits", nb, 24);
    check("bp_word", cap, w);

    // RX of 0x800001.
    w = 24'h800001;
    drv_din_valid = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      check($sformatf("rx_rdy%0d", k), {ser_ready, rx_valid}, 2'b10);
      drv_din = w[k];
      tick();
    end
    check("rx_done", {ser_ready, rx_valid}, 2'b01);
    check("rx_data", rx_data, w);
    drv_din_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_consumed", rx_valid, 0);

    // RX hold with a second word pending.
    w = 24'h13579B; w2 = 24'hECA864;
    drv_din_valid = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin drv_din = w[k]; tick(); end
    check("hold_w1", {7'd0, rx_valid, rx_data}, {8'h01, w});
    drv_din_valid = 1'b0;
    tick();
    drv_din_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_wait", {ser_ready, rx_valid}, 2'b01);
      tick();
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("pend_restart", {ser_ready, rx_valid}, 2'b10);
    for (int k = 0; k < 24; k++) begin
      check($sformatf("pend_rdy%0d", k), ser_ready, 1);
      drv_din = w2[k];
      tick();
    end
    check("pend_w2", {7'd0, rx_valid, rx_data}, {8'h01, w2});
    drv_din_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    check("pend_consumed", {ser_ready, rx_valid}, 2'b00);

    // Round trip through bench wiring.
    ext_lb = 1'b1;
    lb_word(24'h123456, "ext_lb_fixed");
    for (int i = 0; i < 1000; i++) lb_word(24'($urandom), "ext_lb_rand");
    abort_word("ext_abort");
    ext_lb = 1'b0;

`ifdef SERIAL_LOOPBACK_EN
    // Internal loopback with external serial inputs held inert.
    drv_ready = 1'b0; drv_din_valid = 1'b0; drv_din = 1'b1;
    repeat (3) tick();
    lb_int = 1'b1;
    lb_word(24'h123456, "int_lb_fixed");
    for (int i = 0; i < 1000; i++) lb_word(24'($urandom), "int_lb_rand");
    abort_word("int_abort");
    lb_int = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
